// File: rtl/counter_ring_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_ring_seq_ctrl
// Description : Clocked round-robin sequencer for a W-bit NCL dual-rail counter
//               ring; each grant runs one DATA/NULL four-phase cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ring_seq_ctrl #(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic [1:0]       req,
    input  logic [1:0]       req_inc,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic [W-1:0]     count,
    output logic             carry_flag,
    output logic             err,
    output logic [1:0]       carryin,
    output logic             sumcomp,
    input  logic [2*W-1:0]   sumout_dr,
    input  logic [1:0]       carryout_dr
);

    localparam int NP  = W + 1;
    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_DATA    = 3'd2,
        S_CAPTURE = 3'd3,
        S_NULL    = 3'd4,
        S_RELEASE = 3'd5,
        S_DONE    = 3'd6,
        S_ABORT   = 3'd7
    } state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic [2*NP-1:0] r_sync [SYNC_STAGES];
    logic [2*NP-1:0] w_ring;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= {carryout_dr, sumout_dr};
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end
    assign w_ring = r_sync[SYNC_STAGES-1];

    logic [NP-1:0] w_pair_data, w_pair_null, w_pair_bad;
    logic [W-1:0]  w_sum_true;
    logic          w_all_data, w_all_null, w_illegal;

    for (genvar i = 0; i < NP; i++) begin : g_pair
        assign w_pair_data[i] = w_ring[2*i+1] ^ w_ring[2*i];
        assign w_pair_null[i] = ~(w_ring[2*i+1] | w_ring[2*i]);
        assign w_pair_bad[i]  = w_ring[2*i+1] & w_ring[2*i];
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign w_sum_true[i] = w_ring[2*i+1];
    end

    assign w_all_data = &w_pair_data;
    assign w_all_null = &w_pair_null;
    assign w_illegal  = |w_pair_bad;

    state_t          r_state, w_state_nx;
    logic [WCW-1:0]  r_wait;
    logic            r_ptr;
    logic            r_gidx, w_gidx_nx;
    logic            r_inc, w_inc_nx;
    logic            w_err_set;
    logic            w_capture;
    logic            w_timeout;

    assign w_timeout = (r_wait == WCW'(TIMEOUT));

    always_comb begin
        w_state_nx = r_state;
        w_gidx_nx  = r_gidx;
        w_inc_nx   = r_inc;
        w_err_set  = 1'b0;
        w_capture  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|req) w_state_nx = S_ARB;
            end
            S_ARB: begin
                if (req == 2'b11) begin
                    w_gidx_nx  = r_ptr;
                    w_state_nx = S_DATA;
                end else if (req[0]) begin
                    w_gidx_nx  = 1'b0;
                    w_state_nx = S_DATA;
                end else if (req[1]) begin
                    w_gidx_nx  = 1'b1;
                    w_state_nx = S_DATA;
                end else begin
                    w_state_nx = S_IDLE;
                end
                w_inc_nx = req_inc[w_gidx_nx];
            end
            S_DATA: begin
                if (w_illegal || (!w_all_data && w_timeout)) begin
                    w_err_set  = 1'b1;
                    w_state_nx = S_ABORT;
                end else if (w_all_data) begin
                    w_state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_illegal) begin
                    w_err_set  = 1'b1;
                    w_state_nx = S_ABORT;
                end else begin
                    w_capture  = 1'b1;
                    w_state_nx = S_NULL;
                end
            end
            S_NULL: begin
                if (w_illegal || (!w_all_null && w_timeout)) begin
                    w_err_set  = 1'b1;
                    w_state_nx = S_ABORT;
                end else if (w_all_null) begin
                    w_state_nx = S_RELEASE;
                end
            end
            S_RELEASE: w_state_nx = S_DONE;
            S_DONE:    w_state_nx = S_IDLE;
            S_ABORT: begin
                // A ring that never returns to NULL is abandoned without a done pulse.
                if (w_all_null)     w_state_nx = S_DONE;
                else if (w_timeout) w_state_nx = S_IDLE;
            end
            default:   w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they only move on state entry.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_wait     <= '0;
            r_ptr      <= 1'b0;
            r_gidx     <= 1'b0;
            r_inc      <= 1'b0;
            grant      <= 2'b00;
            done       <= 2'b00;
            count      <= '0;
            carry_flag <= 1'b0;
            err        <= 1'b0;
            carryin    <= 2'b00;
            sumcomp    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_gidx  <= w_gidx_nx;
            r_inc   <= w_inc_nx;

            if (w_state_nx != r_state) r_wait <= '0;
            else if (!w_timeout)       r_wait <= r_wait + 1'b1;

            if (w_err_set) err <= 1'b1;

            if (w_capture) begin
                count      <= w_sum_true;
                carry_flag <= w_ring[2*W+1];
            end

            carryin <= (w_state_nx == S_DATA) ? (w_inc_nx ? 2'b10 : 2'b01) : 2'b00;
            sumcomp <= (w_state_nx == S_NULL) || (w_state_nx == S_ABORT);

            if (r_state == S_ARB && w_state_nx == S_DATA)
                grant <= 2'b01 << w_gidx_nx;
            else if (w_state_nx == S_DONE || w_state_nx == S_IDLE)
                grant <= 2'b00;

            done <= (w_state_nx == S_DONE) ? (2'b01 << w_gidx_nx) : 2'b00;

            if (w_state_nx == S_DONE && r_state != S_DONE) r_ptr <= ~r_gidx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_ring_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_ring_seq_ctrl
// Description : Self-checking bench with a behavioural dual-rail ring model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ring_seq_ctrl;

    localparam int W           = 32;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 1023;
    localparam int M_NORMAL    = 0;
    localparam int M_STUCK     = 1;
    localparam int M_ILLEGAL   = 2;

    logic           clk = 1'b0;
    logic           init_n = 1'b0;
    logic [1:0]     req = 2'b00;
    logic [1:0]     req_inc = 2'b00;
    logic [1:0]     grant, done;
    logic [W-1:0]   count;
    logic           carry_flag, err;
    logic [1:0]     carryin;
    logic           sumcomp;
    logic [2*W-1:0] sumout_dr;
    logic [1:0]     carryout_dr;

    int             n_checks = 0;
    int             n_pass = 0;
    int             ring_mode = M_NORMAL;
    bit             preset_go = 1'b0;
    logic [W-1:0]   preset_val = '0;
    logic [W-1:0]   ring_val;

    // Reference state: the counter value and the last requester served.
    logic [W-1:0]   exp_val;
    int             last_served;

    counter_ring_seq_ctrl #(
        .W(W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .init_n(init_n), .req(req), .req_inc(req_inc),
        .grant(grant), .done(done), .count(count), .carry_flag(carry_flag),
        .err(err), .carryin(carryin), .sumcomp(sumcomp),
        .sumout_dr(sumout_dr), .carryout_dr(carryout_dr)
    );

    always #5 clk = ~clk;

    // Ring emulation: answers DATA with the dual-rail sum, NULL with all-zero.
    initial begin : ring_model
        logic [W:0] acc;
        logic [W:0] pend;
        bit         presented;
        int         dly;
        sumout_dr = '0; carryout_dr = 2'b00; ring_val = '0;
        presented = 1'b0; dly = 0; pend = '0; acc = '0;
        forever begin
            @(posedge clk); #1;
            if (!init_n) begin
                sumout_dr = '0; carryout_dr = 2'b00; ring_val = '0;
                presented = 1'b0; dly = 0;
            end else if (preset_go) begin
                ring_val = preset_val;
            end else if (!presented) begin
                if (carryin != 2'b00 && !sumcomp && ring_mode != M_STUCK) begin
                    if (dly > 0) dly--;
                    else begin
                        acc = {1'b0, ring_val} + {{W{1'b0}}, carryin == 2'b10};
                        for (int i = 0; i < W; i++) begin
                            sumout_dr[2*i+1] = acc[i];
                            sumout_dr[2*i]   = ~acc[i];
                        end
                        carryout_dr = {acc[W], ~acc[W]};
                        if (ring_mode == M_ILLEGAL) sumout_dr[11:10] = 2'b11;
                        pend = acc; presented = 1'b1;
                        dly = $urandom_range(0, 3);
                    end
                end
            end else if (carryin == 2'b00 && sumcomp) begin
                if (dly > 0) dly--;
                else begin
                    sumout_dr = '0; carryout_dr = 2'b00; presented = 1'b0;
                    if (ring_mode == M_NORMAL) ring_val = pend[W-1:0];
                    dly = $urandom_range(0, 3);
                end
            end
        end
    end

    function automatic int pick(input logic [1:0] rq, input int last);
        if (rq == 2'b11) return (last == 0) ? 1 : 0;
        return rq[0] ? 0 : 1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        init_n = 1'b0; req = 2'b00; req_inc = 2'b00;
        repeat (3) @(negedge clk);
        init_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_val = '0; last_served = 1;
    endtask

    // Drives one request and collects what the DUT did until done (bounded).
    task automatic run_txn(input logic [1:0] rq, input logic [1:0] inc,
                           input bit drop, input bit hold,
                           output logic [1:0] g, output logic [1:0] d,
                           output int lat_g, output int lat_e,
                           output logic [1:0] ci_g, output logic [1:0] ci_e,
                           output logic sc_e, output bit order_bad);
        logic err0;
        req = rq; req_inc = inc;
        g = 2'b00; d = 2'b00; lat_g = -1; lat_e = -1;
        ci_g = 2'b00; ci_e = 2'b00; sc_e = 1'b0; order_bad = 1'b0; err0 = err;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (carryin != 2'b00 && sumcomp) order_bad = 1'b1;
            if (grant != 2'b00 && lat_g < 0) begin
                g = grant; lat_g = i; ci_g = carryin;
                if (drop) req = 2'b00;
            end
            if (err && !err0 && lat_e < 0) begin
                lat_e = i; ci_e = carryin; sc_e = sumcomp;
            end
            if (done != 2'b00) begin
                d = done;
                break;
            end
        end
        if (!hold) req = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({grant, done, count, carry_flag, err, carryin, sumcomp} !== '0)
            $display("FAIL reset_outputs: got grant=%b done=%b count=%h cf=%b err=%b ci=%b sc=%b required all zero",
                     grant, done, count, carry_flag, err, carryin, sumcomp);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [1:0] g, d, ci_g, ci_e; logic sc_e; int lg, le; bit ob;
        run_txn(2'b01, 2'b01, 1'b0, 1'b0, g, d, lg, le, ci_g, ci_e, sc_e, ob);
        exp_val = exp_val + 1'b1; last_served = 0;
        n_checks++;
        if (lg !== 2 || g !== 2'b01) $display("FAIL basic_grant: got grant=%b latency=%0d required 01 latency 2", g, lg);
        else n_pass++;
        n_checks++;
        if (ci_g !== 2'b10) $display("FAIL basic_carryin: got %b required 10", ci_g);
        else n_pass++;
        n_checks++;
        if (d !== 2'b01 || count !== exp_val || carry_flag !== 1'b0 || ob)
            $display("FAIL basic_result: got done=%b count=%h cf=%b order_bad=%b required 01 %h 0 0", d, count, carry_flag, ob, exp_val);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 2'b00 || grant !== 2'b00 || carryin !== 2'b00 || sumcomp !== 1'b0)
            $display("FAIL basic_after_done: got done=%b grant=%b ci=%b sc=%b required 00 00 00 0", done, grant, carryin, sumcomp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] g, d, ci_g, ci_e; logic sc_e; int lg, le; bit ob; int idx;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_txn(2'b11, 2'b11, 1'b0, 1'b1, g, d, lg, le, ci_g, ci_e, sc_e, ob);
            idx = pick(2'b11, last_served); last_served = idx;
            exp_val = exp_val + 1'b1;
            n_checks++;
            if (g !== 2'(1 << idx) || d !== g || count !== exp_val || ob)
                $display("FAIL rr_txn%0d: got grant=%b done=%b count=%h order_bad=%b required grant=%b count=%h",
                         k, g, d, count, ob, 2'(1 << idx), exp_val);
            else n_pass++;
        end
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [1:0] g, d, ci_g, ci_e; logic sc_e; int lg, le; bit ob;
        do_reset();
        preset_val = '1; preset_go = 1'b1;
        repeat (2) @(negedge clk);
        preset_go = 1'b0; exp_val = '1;
        run_txn(2'b01, 2'b01, 1'b0, 1'b0, g, d, lg, le, ci_g, ci_e, sc_e, ob);
        n_checks++;
        if (d !== 2'b01 || count !== '0 || carry_flag !== 1'b1)
            $display("FAIL wrap_inc: got done=%b count=%h cf=%b required 01 00000000 1", d, count, carry_flag);
        else n_pass++;
        exp_val = '0; last_served = 0;
        @(negedge clk);
        run_txn(2'b10, 2'b00, 1'b0, 1'b0, g, d, lg, le, ci_g, ci_e, sc_e, ob);
        last_served = 1;
        n_checks++;
        if (d !== 2'b10 || ci_g !== 2'b01 || count !== exp_val || carry_flag !== 1'b0)
            $display("FAIL wrap_read: got done=%b ci=%b count=%h cf=%b required 10 01 %h 0", d, ci_g, count, carry_flag, exp_val);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_req_drop();
        logic [1:0] g, d, ci_g, ci_e; logic sc_e; int lg, le; bit ob;
        run_txn(2'b10, 2'b10, 1'b1, 1'b0, g, d, lg, le, ci_g, ci_e, sc_e, ob);
        exp_val = exp_val + 1'b1; last_served = 1;
        n_checks++;
        if (g !== 2'b10 || d !== 2'b10 || count !== exp_val || err !== 1'b0)
            $display("FAIL req_drop: got grant=%b done=%b count=%h err=%b required 10 10 %h 0", g, d, count, err, exp_val);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0] g, d, ci_g, ci_e, rq, inc; logic sc_e; int lg, le; bit ob; int idx;
        logic [W:0] sum;
        for (int k = 0; k < 8; k++) begin
            rq  = 2'($urandom_range(1, 3));
            inc = 2'($urandom_range(0, 3));
            run_txn(rq, inc, 1'($urandom_range(0, 1)), 1'b0, g, d, lg, le, ci_g, ci_e, sc_e, ob);
            idx = pick(rq, last_served); last_served = idx;
            sum = {1'b0, exp_val} + {{W{1'b0}}, inc[idx]};
            exp_val = sum[W-1:0];
            n_checks++;
            if (g !== 2'(1 << idx) || d !== g || count !== exp_val || carry_flag !== sum[W] || ob)
                $display("FAIL random_txn%0d: got grant=%b done=%b count=%h cf=%b required grant=%b count=%h cf=%b",
                         k, g, d, count, carry_flag, 2'(1 << idx), exp_val, sum[W]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] g, d, ci_g, ci_e; logic sc_e; int lg, le; bit ob;
        do_reset();
        ring_mode = M_STUCK;
        run_txn(2'b01, 2'b01, 1'b0, 1'b0, g, d, lg, le, ci_g, ci_e, sc_e, ob);
        ring_mode = M_NORMAL;
        n_checks++;
        if (le < 0 || (le - lg) < TIMEOUT || (le - lg) > TIMEOUT + 1)
            $display("FAIL timeout_latency: got %0d cycles required %0d..%0d", le - lg, TIMEOUT, TIMEOUT + 1);
        else n_pass++;
        n_checks++;
        if (ci_e !== 2'b00 || sc_e !== 1'b1 || d !== 2'b01 || count !== '0 || err !== 1'b1)
            $display("FAIL timeout_abort: got ci=%b sc=%b done=%b count=%h err=%b required 00 1 01 0 1", ci_e, sc_e, d, count, err);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [1:0] g, d, ci_g, ci_e; logic sc_e; int lg, le; bit ob;
        do_reset();
        ring_mode = M_ILLEGAL;
        run_txn(2'b01, 2'b01, 1'b0, 1'b0, g, d, lg, le, ci_g, ci_e, sc_e, ob);
        ring_mode = M_NORMAL;
        n_checks++;
        if (le < 0 || ci_e !== 2'b00 || sc_e !== 1'b1 || d !== 2'b01 || (le - lg) >= TIMEOUT)
            $display("FAIL illegal_abort: got err_at=%0d ci=%b sc=%b done=%b required early abort 00 1 01", le - lg, ci_e, sc_e, d);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00 || sumcomp !== 1'b0 || carryin !== 2'b00 || sumout_dr !== '0 || err !== 1'b1)
            $display("FAIL illegal_idle: got grant=%b sc=%b ci=%b ring=%h err=%b required 00 0 00 0 1", grant, sumcomp, carryin, sumout_dr, err);
        else n_pass++;
        run_txn(2'b01, 2'b01, 1'b0, 1'b0, g, d, lg, le, ci_g, ci_e, sc_e, ob);
        exp_val = exp_val + 1'b1;
        n_checks++;
        if (d !== 2'b01 || count !== exp_val)
            $display("FAIL illegal_recover: got done=%b count=%h required 01 %h", d, count, exp_val);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [1:0] g, d, ci_g, ci_e; logic sc_e; int lg, le; bit ob; bit found;
        do_reset();
        req = 2'b01; req_inc = 2'b01; found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sumcomp) begin
                found = 1'b1;
                break;
            end
        end
        init_n = 1'b0; req = 2'b00;
        #1;
        n_checks++;
        if (!found || carryin !== 2'b00 || sumcomp !== 1'b0 || grant !== 2'b00 || done !== 2'b00)
            $display("FAIL reset_mid: got reached_null=%b ci=%b sc=%b grant=%b done=%b required 1 00 0 00 00", found, carryin, sumcomp, grant, done);
        else n_pass++;
        repeat (2) @(negedge clk);
        init_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_val = '0; last_served = 1;
        run_txn(2'b01, 2'b01, 1'b0, 1'b0, g, d, lg, le, ci_g, ci_e, sc_e, ob);
        exp_val = exp_val + 1'b1;
        n_checks++;
        if (d !== 2'b01 || count !== exp_val || err !== 1'b0)
            $display("FAIL reset_mid_resume: got done=%b count=%h err=%b required 01 %h 0", d, count, err, exp_val);
        else n_pass++;
    endtask

    initial begin
        exp_val = '0; last_served = 1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_req_drop();
        test_random();
        test_timeout();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
